// File: rtl/frame_buffer_pingpong.sv
// Double-buffered frame store: the writer fills one bank while the reader scans the other,
// and banks swap only on frame boundaries so the reader never sees a partial frame.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// EMPTY   | no complete frame yet; waiting for the first wr_frame_end
// SHOWING | read bank holds a complete frame; writer filling the other bank
// PENDING | writer finished a frame; waiting for the reader to release its bank

module frame_buffer_pingpong #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_frame_end,
   output logic              wr_busy,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_frame_end,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              frame_ready,
   output logic              wr_bank,
   output logic              rd_bank,
   output logic              wr_oob,
   output logic              rd_oob,
   output logic              overrun
);

   localparam int DEPTH = IMG_W * IMG_H;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

   if ((64'(1) << ADDR_W) < 64'(DEPTH)) begin : g_addr_chk
      $error("frame_buffer_pingpong: ADDR_W too small for IMG_W*IMG_H");
   end

   typedef enum logic [1:0] {EMPTY, SHOWING, PENDING} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [2][DEPTH];
   logic              wr_in_range;
   logic              rd_in_range;
   logic              wr_accept;

   assign wr_in_range = {1'b0, wr_addr} < DEPTH_A;
   assign rd_in_range = {1'b0, rd_addr} < DEPTH_A;
   assign wr_accept   = wr_en && !wr_busy && wr_in_range;

   // Storage carries no reset; contents survive rst, only the reset-cycle write is blocked.
   always_ff @(posedge clk) begin
      if (!rst && wr_accept) begin
         mem[wr_bank][wr_addr[IDX_W-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_oob   <= 1'b0;
         wr_oob   <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         rd_oob   <= rd_en && !rd_in_range;
         wr_oob   <= wr_en && !wr_busy && !wr_in_range;
         if (rd_en) begin
            rd_data <= rd_in_range ? mem[rd_bank][rd_addr[IDX_W-1:0]] : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= EMPTY;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b1;
         frame_ready <= 1'b0;
         wr_busy     <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         overrun <= 1'b0;
         unique case (state)
            EMPTY: begin
               if (wr_frame_end) begin
                  wr_bank     <= ~wr_bank;
                  rd_bank     <= ~rd_bank;
                  frame_ready <= 1'b1;
                  state       <= SHOWING;
               end
            end
            SHOWING: begin
               if (wr_frame_end && rd_frame_end) begin
                  wr_bank <= ~wr_bank;
                  rd_bank <= ~rd_bank;
               end else if (wr_frame_end) begin
                  wr_busy <= 1'b1;
                  state   <= PENDING;
               end
            end
            PENDING: begin
               // A second finished frame has nowhere to go; it is discarded and flagged.
               if (wr_frame_end) begin
                  overrun <= 1'b1;
               end
               if (rd_frame_end) begin
                  wr_bank <= ~wr_bank;
                  rd_bank <= ~rd_bank;
                  wr_busy <= 1'b0;
                  state   <= SHOWING;
               end
            end
            default: begin
               state <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: doc/frame_buffer_pingpong.md
# frame_buffer_pingpong

Parametrised double-buffered image store that replaces the single-bank frame memory between the camera/processing writer and the display/readout reader. Two banks of IMG_W×IMG_H pixels are used: the writer fills one bank while the reader scans the other, and a small state machine swaps banks on frame boundaries so the reader never sees a partially written frame. Out-of-range accesses are dropped and flagged rather than clamped.

## Interface

- DATA_W, 8, pixel width in bits
- IMG_W, 320, image width in pixels
- IMG_H, 240, image height in pixels
- ADDR_W, 17, address width; 2^ADDR_W must be ≥ IMG_W*IMG_H (elaboration error otherwise)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  pixel address within the write bank
- wr_data  in  DATA_W  pixel data
- wr_frame_end  in  1  one-cycle pulse: writer has finished the frame in the write bank
- wr_busy  out  1  high in PENDING; wr_en is ignored while high
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_W  pixel address within the read bank
- rd_frame_end  in  1  one-cycle pulse: reader has finished scanning the current frame
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  high one cycle after an accepted rd_en
- frame_ready  out  1  read bank holds a complete frame
- wr_bank  out  1  bank index currently written
- rd_bank  out  1  bank index currently read
- wr_oob  out  1  one-cycle pulse: write dropped, address ≥ IMG_W*IMG_H
- rd_oob  out  1  one-cycle pulse, coincident with rd_valid: read address out of range
- overrun  out  1  one-cycle pulse: wr_frame_end arrived in PENDING and was discarded

## Operation

- Storage: 2*IMG_W*IMG_H words of DATA_W, bank-select bit + in-bank address. wr_bank != rd_bank at all times, so there is never a same-location read/write collision.
- Write: if wr_en && !wr_busy && wr_addr < IMG_W*IMG_H, mem[wr_bank][wr_addr] <= wr_data. Out-of-range: no write, wr_oob=1 next cycle. A write in the same cycle as wr_frame_end goes to the old wr_bank.
- Read: on rd_en, rd_data <= mem[rd_bank][rd_addr], or 0 if out of range (rd_oob=1). Reads are always served, whatever frame_ready is.
- FSM states: EMPTY, SHOWING, PENDING.
  - EMPTY: wr_frame_end -> swap, frame_ready<=1, go to SHOWING. rd_frame_end is ignored.
  - SHOWING: wr_frame_end without rd_frame_end -> PENDING (no swap). rd_frame_end alone -> stay; the reader repeats the same frame. Both in the same cycle -> swap, stay SHOWING.
  - PENDING: rd_frame_end -> swap, go to SHOWING. wr_frame_end -> overrun pulse, stay PENDING, no swap.
- Swap: wr_bank and rd_bank both toggle in the same edge.
- Reset (any time, including mid-frame or PENDING): state EMPTY, wr_bank=0, rd_bank=1. frame_ready, wr_busy, rd_valid, rd_data, wr_oob, rd_oob and overrun are all 0. Memory contents are not cleared. A read or write issued in the reset cycle has no effect.

## Timing

- Read latency is 1 cycle: rd_en at edge N gives rd_data/rd_valid/rd_oob valid after edge N+1. Back-to-back reads run at full rate.
- Write completes at the edge where it is presented. wr_oob asserts after the following edge for one cycle.
- Swap is registered at the edge where the triggering pulse is sampled. Reads and writes issued from the next cycle onward use the new banks. A read issued in the swap cycle uses the old rd_bank.
- wr_busy rises the cycle after wr_frame_end enters PENDING. It falls the cycle after the swap.
- overrun is a one-cycle pulse, asserted after the edge sampling the offending wr_frame_end.

## Test plan

- Reset, write 0x00..0xFF to addresses 0..255, pulse wr_frame_end -> frame_ready=1, rd_bank=0, wr_bank=1; reading addresses 0..255 returns the same values, each 1 cycle after rd_en.
- Write addr 76800 (defaults) with data 0xAA -> no memory change, wr_oob pulse; read addr 76800 -> rd_data=0, rd_oob=1, rd_valid=1.
- SHOWING, pulse wr_frame_end -> wr_busy=1 and writes are ignored (the bank is unchanged). Pulse rd_frame_end -> banks swap, wr_busy=0, and the new frame is visible on the next read.
- In PENDING, pulse wr_frame_end again -> overrun=1 for one cycle, no swap, still PENDING.
- SHOWING, pulse wr_frame_end and rd_frame_end in the same cycle -> immediate swap, stays SHOWING, wr_busy never rises.
- Assert rst while in PENDING -> next cycle EMPTY, wr_bank=0, rd_bank=1, frame_ready=0, wr_busy=0; previously written data is still readable at the retained addresses.
